// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reads back a multiplexed active-low seven-segment bus and
// rebuilds the packed hex value once every digit has been seen stably.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    frame_valid,
    output logic                    invalid_pat,
    output logic                    busy
);
    typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;
    localparam logic [NUM_DIGITS-1:0] ALL = '1;
    // Code for nibble k lives at bits [7k+6:7k], ABCDEFG with A as MSB.
    localparam logic [16*7-1:0] CODES = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };
    logic [6:0]              seg_m_q, seg_s_q, seg_p_q;
    logic [NUM_DIGITS-1:0]   an_m_q, an_s_q, an_p_q;
    state_t                  state_q, state_d, state_n;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, value_q, value_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    fv_q, fv_d, inv_q, inv_d;
    logic                    pair_ok, changed, restart, cap, match, done;
    logic [3:0]              nib;

    always_comb begin
        pair_ok = $countones(~an_s_q) == 1;
        changed = (seg_s_q != seg_p_q) || (an_s_q != an_p_q);
        match   = 1'b0;
        nib     = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (seg_s_q == CODES[7*k +: 7]) begin
                match = 1'b1;
                nib   = 4'(k);
            end
        end
        restart = (state_q == WAIT) || changed;
        cnt_d   = restart ? (pair_ok ? 8'd1 : 8'd0)
                          : (state_q == COUNT ? cnt_q + 8'd1 : cnt_q);
        state_n = restart ? (pair_ok ? COUNT : WAIT) : state_q;
        cap     = (state_n == COUNT) && (cnt_d == 8'(STABLE_CYCLES));
        state_d = cap ? HELD : state_n;
        // Completion clears seen first so a same-cycle capture opens the next frame.
        done    = seen_q == ALL;
        value_d = done ? shadow_q : value_q;
        fv_d    = done;
        seen_d  = done ? '0 : seen_q;
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && match && !an_s_q[i]) begin
                shadow_d[4*i +: 4] = nib;
                seen_d[i]          = 1'b1;
            end
        end
        inv_d = cap && !match;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_m_q  <= 7'h7F;
            seg_s_q  <= 7'h7F;
            seg_p_q  <= 7'h7F;
            an_m_q   <= ALL;
            an_s_q   <= ALL;
            an_p_q   <= ALL;
            state_q  <= WAIT;
            cnt_q    <= 8'd0;
            shadow_q <= '0;
            seen_q   <= '0;
            value_q  <= '0;
            fv_q     <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            seg_m_q  <= seg;
            seg_s_q  <= seg_m_q;
            seg_p_q  <= seg_s_q;
            an_m_q   <= an;
            an_s_q   <= an_m_q;
            an_p_q   <= an_s_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            value_q  <= value_d;
            fv_q     <= fv_d;
            inv_q    <= inv_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign invalid_pat = inv_q;
    assign busy        = (seen_q != '0) && (seen_q != ALL);
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scans against a run-length model of the readback monitor.
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg = 7'h7F, seg1 = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [0:0]  an1 = 1'b1;
    logic [15:0] value;
    logic [3:0]  value1;
    logic        fv, inv, busy, fv1, inv1, busy1;

    always #5 clk = ~clk;

    seg_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .value(value), .frame_valid(fv), .invalid_pat(inv), .busy(busy));

    seg_scan_capture #(.NUM_DIGITS(1), .STABLE_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .seg(seg1), .an(an1),
        .value(value1), .frame_valid(fv1), .invalid_pat(inv1), .busy(busy1));

    int checks = 0, failures = 0, fv_cnt = 0, inv_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: pat = 7'b0000001;  4'h1: pat = 7'b1001111;
            4'h2: pat = 7'b0010010;  4'h3: pat = 7'b0000110;
            4'h4: pat = 7'b1001100;  4'h5: pat = 7'b0100100;
            4'h6: pat = 7'b0100000;  4'h7: pat = 7'b0001111;
            4'h8: pat = 7'b0000000;  4'h9: pat = 7'b0000100;
            4'hA: pat = 7'b0001000;  4'hB: pat = 7'b1100000;
            4'hC: pat = 7'b0110001;  4'hD: pat = 7'b1000010;
            4'hE: pat = 7'b0110000;  default: pat = 7'b0111000;
        endcase
    endfunction

    // Model: pins seen two edges late; a valid pair is captured when its run length hits 4.
    logic [6:0]  s1 = 7'h7F, s2 = 7'h7F, pseg = 7'h7F, cs;
    logic [3:0]  a1 = 4'hF, a2 = 4'hF, pan = 4'hF, ca, nibm, mseen = 4'h0;
    logic [15:0] mval = 16'h0, mshad = 16'h0;
    logic        mfv = 1'b0, minv = 1'b0, found;
    int          run = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            s1 = 7'h7F; s2 = 7'h7F; pseg = 7'h7F;
            a1 = 4'hF;  a2 = 4'hF;  pan = 4'hF;
            run = 0; mval = 0; mshad = 0; mseen = 0; mfv = 0; minv = 0;
        end else begin
            cs = s2;
            ca = a2;
            run = (cs == pseg && ca == pan) ? run + 1 : 1;
            pseg = cs;
            pan = ca;
            mfv = 0;
            minv = 0;
            if (mseen == 4'hF) begin
                mval = mshad;
                mfv = 1;
                mseen = 0;
            end
            if ($countones(~ca) == 1 && run == 4) begin
                found = 0;
                nibm = 0;
                for (int k = 0; k < 16; k++)
                    if (pat(4'(k)) == cs) begin found = 1; nibm = 4'(k); end
                if (found) begin
                    for (int d = 0; d < 4; d++)
                        if (!ca[d]) begin mshad[4*d +: 4] = nibm; mseen[d] = 1'b1; end
                end else minv = 1;
            end
            s2 = s1; a2 = a1; s1 = seg; a1 = an;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("value", value, mval);
        chk("frame_valid", fv, mfv);
        chk("invalid_pat", inv, minv);
        chk("busy", busy, (mseen != 0) && (mseen != 4'hF));
        if (fv) fv_cnt++;
        if (inv) inv_cnt++;
    end

    task automatic show(input logic [6:0] s, input logic [3:0] a, input int n);
        @(negedge clk);
        seg = s;
        an = a;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] v, input int nd);
        for (int d = 0; d < nd; d++) show(pat(v[4*d +: 4]), ~(4'b0001 << d), 8);
    endtask

    int f0, i0;

    initial begin
        @(negedge clk);
        chk("rst_value", value, 0);
        chk("rst_fv", fv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inv", inv, 0);
        @(posedge clk); #2 reset = 1'b0;
        // Single digit latency: pins set before edge 0, frame_valid visible after edge 6.
        @(negedge clk);
        seg1 = pat(4'h3);
        an1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("lat_fv1_edge%0d", k), fv1, k == 6);
            chk($sformatf("lat_busy1_edge%0d", k), busy1, 0);
        end
        chk("lat_value1", value1, 4'h3);
        chk("lat_inv1", inv1, 0);
        // Normal scan
        f0 = fv_cnt;
        scan(16'h4321, 2);
        show(pat(4'h3), 4'b1011, 3);
        chk("scan_busy_mid", busy, 1);
        show(pat(4'h3), 4'b1011, 5);
        show(pat(4'h4), 4'b0111, 8);
        show(7'h7F, 4'hF, 6);
        chk("scan_frames", fv_cnt - f0, 1);
        chk("scan_value", value, 16'h4321);
        chk("scan_model", mval, 16'h4321);
        chk("scan_busy_end", busy, 0);
        // Glitch rejection on digit 0
        f0 = fv_cnt;
        show(pat(4'h8), 4'hE, 3);
        show(pat(4'h9), 4'hE, 6);
        for (int d = 1; d < 4; d++) show(pat(4'(d + 1)), ~(4'b0001 << d), 8);
        show(7'h7F, 4'hF, 6);
        chk("glitch_value", value, 16'h4329);
        chk("glitch_frames", fv_cnt - f0, 1);
        // Invalid pattern on digit 2
        f0 = fv_cnt;
        i0 = inv_cnt;
        show(7'h7F, 4'b1011, 10);
        show(7'h7F, 4'hF, 4);
        chk("invpat_pulses", inv_cnt - i0, 1);
        chk("invpat_busy", busy, 0);
        chk("invpat_frames", fv_cnt - f0, 0);
        // Invalid anode patterns
        i0 = inv_cnt;
        show(pat(4'h1), 4'h0, 10);
        show(pat(4'h1), 4'hF, 10);
        chk("invan_busy", busy, 0);
        chk("invan_inv", inv_cnt - i0, 0);
        chk("invan_frames", fv_cnt - f0, 0);
        scan(16'h8765, 4);
        show(7'h7F, 4'hF, 6);
        chk("invan_value", value, 16'h8765);
        chk("invan_frames2", fv_cnt - f0, 1);
        // Reset mid-frame
        scan(16'h0CBA, 3);
        show(7'h7F, 4'hF, 6);
        chk("rstmid_busy_before", busy, 1);
        f0 = fv_cnt;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("rstmid_value", value, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_fv", fv, 0);
        @(posedge clk); #2 reset = 1'b0;
        scan(16'hBCDE, 4);
        show(7'h7F, 4'hF, 6);
        chk("rstmid_frames", fv_cnt - f0, 1);
        chk("rstmid_scan_value", value, 16'hBCDE);
        chk("rstmid_model", mval, 16'hBCDE);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Readback monitor on the multiplexed seven-segment display bus: the inverse of the hex-to-segment decoder.
- Samples the active-low segment lines and active-low digit anodes.
- Waits until each digit's pattern is stable, encodes it back to a 4-bit hex nibble, and assembles a packed multi-digit value.
- Sits beside the display driver, so stopwatch logic and benches can check what is actually being shown.

Parameters:
NUM_DIGITS, 4, number of scanned digits/anodes (1..8)
STABLE_CYCLES, 4, consecutive synchronized cycles a pattern/anode pair must hold before capture (1..255; internal counter fixed at 8 bits)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
seg  input  7  segment lines {A,B,C,D,E,F,G}, A = MSB, active-low
an  input  NUM_DIGITS  digit enables, active-low, bit i = digit i (digit 0 = least-significant nibble)
value  output  4*NUM_DIGITS  last complete frame, digit i in bits [4i+3:4i]
frame_valid  output  1  one-cycle pulse when value is updated
invalid_pat  output  1  one-cycle pulse when a stable pattern matches no code
busy  output  1  high while at least one but not all digits of the current frame are captured

Behaviour:
- Reset: value=0, frame_valid=0, invalid_pat=0, busy=0.
  - Sync flops reset to seg=7'h7F and an=all-ones.
  - Shadow register=0, seen mask=0, counter=0, state=WAIT.
- Input synchronization:
  - seg and an pass through 2 flops to form seg_s/an_s.
  - Pins changed before edge 0 appear on seg_s/an_s after edge 1.
- Valid pair: an_s has exactly one bit low. Anything else (all high, or multiple low) is invalid.
- Code table, ABCDEFG -> nibble:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
  - Any other pattern is invalid.
- FSM states: WAIT, COUNT, HELD.
  - WAIT:
    - Pair invalid: stay in WAIT, counter=0.
    - Pair valid: go to COUNT, counter=1.
  - COUNT:
    - Pair changes (seg_s or an_s differs from the previous cycle): counter restarts at 1 if the new pair is valid, otherwise go to WAIT.
    - Pair unchanged: counter increments.
    - When the pair has been held STABLE_CYCLES consecutive cycles, capture on that edge and go to HELD.
  - HELD:
    - Pair unchanged: stay in HELD, no re-capture.
    - Any change: go to COUNT (counter=1) if valid, otherwise WAIT.
  - STABLE_CYCLES=1: capture on the first cycle a valid pair is seen.
- Capture at digit idx (the low bit of an_s):
  - Pattern matches a code: shadow[idx] <= nibble and seen[idx] <= 1. Re-capturing an already-seen digit within a frame overwrites its nibble.
  - No match: invalid_pat pulses on the next cycle; shadow and seen are unchanged.
- Capture latency: pins stable from before edge 0 are captured at edge STABLE_CYCLES+1.
- Frame completion:
  - At the edge after the capture that makes seen all-ones: value <= shadow, frame_valid=1 for exactly one cycle, seen <= 0.
  - The shadow register is retained.
  - A capture landing in that same cycle is applied after the clear and counts toward the next frame.
- busy = (seen != 0) and (seen != all-ones).
- Reset asserted mid-frame: all state is discarded immediately, with no frame_valid. After release, the previous value reads 0.
- Asynchronous pins are only consumed via the synchronizers; no combinational path from inputs to outputs.

Test Plan:
- Digit 0 only, NUM_DIGITS=1, STABLE_CYCLES=4: seg=0000110 and an=0 applied before edge 0 -> capture at edge 5; frame_valid high one cycle after edge 6; value=4'h3.
- Normal scan, NUM_DIGITS=4: cycle digits 0..3 with patterns for 1,2,3,4, each held 8 cycles -> a single frame_valid with value=16'h4321; busy high from the first capture until the frame completes.
- Glitch rejection: pattern for 8 held 3 cycles, then the pattern for 9 held 6 cycles on the same anode -> no capture of 8; digit captured as 9.
- Invalid pattern: seg=1111111 held 10 cycles on digit 2 -> exactly one invalid_pat pulse; seen[2] stays 0; no frame_valid.
- Invalid anodes: an=4'b0000 and then 4'b1111 with valid segment data -> no captures, busy=0; a subsequent full valid scan yields the correct frame.
- Reset mid-frame: three of four digits captured, then reset pulsed -> outputs 0, busy=0. A following full scan of E,D,C,B yields value=16'hBCDE.
